// File: rtl/mult_result_accumulator.sv
// Sums N_PRODUCTS consecutive results from the 8x8 sequential multiplier.
// Each result is taken on busy's falling edge. The sum is offered on a valid/ready handshake.
module mult_result_accumulator #(
  parameter int N_PRODUCTS = 4,   // products per result, 1..255
  parameter int ACC_W      = 20   // accumulator width, >= 16
) (
  input  logic             clk,
  input  logic             resetL,
  input  logic             start,
  input  logic             busy_in,
  input  logic [15:0]      product_in,
  output logic [ACC_W-1:0] result_out,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [7:0]       count,
  output logic             overflow,
  output logic             dropped
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] N_LAST = 8'(N_PRODUCTS);

  state_t           r_state;
  logic             r_busy_q;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_result;
  logic             r_valid;
  logic [7:0]       r_count;
  logic             r_overflow;
  logic             r_dropped;

  logic             w_done;
  logic [ACC_W:0]   w_sum;
  logic [7:0]       w_count_inc;
  logic             w_last;

  // A completion is the first cycle in which busy is seen low after being high.
  assign w_done      = r_busy_q & ~busy_in;
  assign w_sum       = {1'b0, r_acc} + (ACC_W+1)'(product_in);
  assign w_count_inc = r_count + 8'd1;
  assign w_last      = (w_count_inc == N_LAST);

  // Register busy_in so that its falling edge can be detected.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      r_busy_q <= 1'b0;
    end else begin
      r_busy_q <= busy_in;
    end
  end

  // Sequence control: accumulate, hold the finished result, and keep the sticky flags.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_count    <= 8'd0;
      r_overflow <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_count    <= 8'd0;
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
            r_state    <= ST_ACCUM;
          end else if (w_done) begin
            r_dropped <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (start) begin
            // A restart discards any completion that lands in the same cycle.
            r_acc      <= '0;
            r_count    <= 8'd0;
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
          end else if (w_done) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_count <= w_count_inc;
            if (w_sum[ACC_W]) begin
              r_overflow <= 1'b1;
            end
            if (w_last) begin
              r_result <= w_sum[ACC_W-1:0];
              r_valid  <= 1'b1;
              r_state  <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_done) begin
            r_dropped <= 1'b1;
          end
          if (result_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign result_out   = r_result;
  assign result_valid = r_valid;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign dropped      = r_dropped;

endmodule
